// File: rtl/uart_cmd_decoder_if.sv
// Byte stream and memory port bundle between uart_cmd_decoder and its environment.
// slave is the decoder side; master is the uart/memory side.
interface uart_cmd_decoder_if #(
  parameter int unsigned XLEN = 32
);
  logic [7:0]      rx_data;
  logic            rx_data_vld;
  logic            rx_data_rdy;
  logic [7:0]      tx_data;
  logic            tx_data_vld;
  logic            tx_data_rdy;
  logic [XLEN-1:0] mem_wr_addr;
  logic [XLEN-1:0] mem_wr_data;
  logic [3:0]      mem_wr_byte_en;
  logic [XLEN-1:0] mem_rd_addr;
  logic [XLEN-1:0] mem_rd_data;

  modport slave (
    input  rx_data, rx_data_vld, tx_data_rdy, mem_rd_data,
    output rx_data_rdy, tx_data, tx_data_vld, mem_wr_addr, mem_wr_data, mem_wr_byte_en,
           mem_rd_addr
  );

  modport master (
    output rx_data, rx_data_vld, tx_data_rdy, mem_rd_data,
    input  rx_data_rdy, tx_data, tx_data_vld, mem_wr_addr, mem_wr_data, mem_wr_byte_en,
           mem_rd_addr
  );
endinterface

// File: rtl/uart_cmd_decoder.sv
// Host UART command responder: decodes CPU reset/run, config and byte-addressed memory
// load/readback commands from the rx byte stream.
module uart_cmd_decoder #(
  parameter int unsigned XLEN = 32
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  uart_cmd_decoder_if.slave bus_if,
  output logic              cpu_rst_n_o
);

  typedef enum logic [2:0] {
    StIdle,
    StConfWr,
    StConfRd,
    StDataWr,
    StRdAddr,
    StRdWait,
    StRdSend
  } state_e;

  state_e          state_q, state_d;
  logic [XLEN-1:0] base_q, base_d;
  logic [XLEN-1:0] len_q, len_d;
  logic [XLEN-1:0] cnt_q, cnt_d;
  logic [XLEN-1:0] addr_q, addr_d;
  logic [XLEN-1:0] wr_addr_q, wr_addr_d;
  logic [XLEN-1:0] wr_data_q, wr_data_d;
  logic [3:0]      wr_be_q, wr_be_d;
  logic [7:0]      tx_data_q, tx_data_d;
  logic            tx_vld_q, tx_vld_d;
  logic            cpu_rst_n_q, cpu_rst_n_d;

  logic            rx_rdy;
  logic            rx_fire;
  logic            tx_fire;
  logic            last_byte;
  logic [2:0]      cfg_idx_next;
  logic [2*XLEN-1:0] cfg_shifted;
  logic [XLEN-1:0] rd_shifted;

  assign rx_rdy       = (state_q == StIdle) || (state_q == StConfWr) || (state_q == StDataWr);
  assign rx_fire      = bus_if.rx_data_vld && rx_rdy;
  assign tx_fire      = tx_vld_q && bus_if.tx_data_rdy;
  // Compare before incrementing so len = all-ones still terminates after 2^XLEN bytes.
  assign last_byte    = (cnt_q == len_q);
  assign cfg_idx_next = cnt_q[2:0] + 3'd1;
  assign cfg_shifted  = {len_q, base_q} >> {cfg_idx_next, 3'b000};
  assign rd_shifted   = bus_if.mem_rd_data >> {addr_q[1:0], 3'b000};

  always_comb begin
    state_d     = state_q;
    base_d      = base_q;
    len_d       = len_q;
    cnt_d       = cnt_q;
    addr_d      = addr_q;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    wr_be_d     = 4'b0000;
    tx_data_d   = tx_data_q;
    tx_vld_d    = tx_vld_q;
    cpu_rst_n_d = cpu_rst_n_q;

    unique case (state_q)
      StIdle: begin
        if (rx_fire) begin
          case (bus_if.rx_data)
            8'h2a: cpu_rst_n_d = 1'b0;
            8'h2b: cpu_rst_n_d = 1'b1;
            8'h2c: begin
              state_d = StConfWr;
              cnt_d   = '0;
            end
            8'h2d: begin
              state_d   = StConfRd;
              cnt_d     = '0;
              tx_data_d = base_q[7:0];
              tx_vld_d  = 1'b1;
            end
            8'h2e: begin
              state_d = StDataWr;
              cnt_d   = '0;
              addr_d  = base_q;
            end
            8'h2f: begin
              state_d = StRdAddr;
              cnt_d   = '0;
              addr_d  = base_q;
            end
            default: ;
          endcase
        end
      end
      StConfWr: begin
        if (rx_fire) begin
          if (cnt_q[2]) begin
            len_d[{cnt_q[1:0], 3'b000} +: 8] = bus_if.rx_data;
          end else begin
            base_d[{cnt_q[1:0], 3'b000} +: 8] = bus_if.rx_data;
          end
          if (cnt_q[2:0] == 3'd7) begin
            state_d = StIdle;
          end else begin
            cnt_d = cnt_q + XLEN'(1);
          end
        end
      end
      StConfRd: begin
        if (tx_fire) begin
          if (cnt_q[2:0] == 3'd7) begin
            state_d  = StIdle;
            tx_vld_d = 1'b0;
          end else begin
            cnt_d     = cnt_q + XLEN'(1);
            tx_data_d = cfg_shifted[7:0];
          end
        end
      end
      StDataWr: begin
        if (rx_fire) begin
          wr_addr_d = {addr_q[XLEN-1:2], 2'b00};
          wr_data_d = {(XLEN/8){bus_if.rx_data}};
          wr_be_d   = 4'b0001 << addr_q[1:0];
          if (last_byte) begin
            state_d = StIdle;
          end else begin
            cnt_d  = cnt_q + XLEN'(1);
            addr_d = addr_q + XLEN'(1);
          end
        end
      end
      StRdAddr: state_d = StRdWait;
      StRdWait: begin
        state_d   = StRdSend;
        tx_data_d = rd_shifted[7:0];
        tx_vld_d  = 1'b1;
      end
      StRdSend: begin
        if (tx_fire) begin
          tx_vld_d = 1'b0;
          if (last_byte) begin
            state_d = StIdle;
          end else begin
            state_d = StRdAddr;
            cnt_d   = cnt_q + XLEN'(1);
            addr_d  = addr_q + XLEN'(1);
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q     <= StIdle;
      base_q      <= '0;
      len_q       <= '0;
      cnt_q       <= '0;
      addr_q      <= '0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      wr_be_q     <= '0;
      tx_data_q   <= '0;
      tx_vld_q    <= 1'b0;
      cpu_rst_n_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      base_q      <= base_d;
      len_q       <= len_d;
      cnt_q       <= cnt_d;
      addr_q      <= addr_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      wr_be_q     <= wr_be_d;
      tx_data_q   <= tx_data_d;
      tx_vld_q    <= tx_vld_d;
      cpu_rst_n_q <= cpu_rst_n_d;
    end
  end

  assign bus_if.rx_data_rdy    = rx_rdy;
  assign bus_if.tx_data        = tx_data_q;
  assign bus_if.tx_data_vld    = tx_vld_q;
  assign bus_if.mem_wr_addr    = wr_addr_q;
  assign bus_if.mem_wr_data    = wr_data_q;
  assign bus_if.mem_wr_byte_en = wr_be_q;
  assign bus_if.mem_rd_addr    = {addr_q[XLEN-1:2], 2'b00};
  assign cpu_rst_n_o           = cpu_rst_n_q;

endmodule
